// File: rtl/window_line_buffer.sv
// rtl/window_line_buffer.sv - WIN x WIN sliding pixel window over buffered image lines
//
// Holds WIN-1 previous image lines in circular line memories addressed by column.
// Each row of the window has a WIN-deep horizontal shift register. A full WIN x WIN
// neighbourhood is produced for every accepted pixel.
//
// Optional feature: define WINDOW_LINE_BUFFER_SOF_ERR_EN to add the sof_err output.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   pixel_in      input pixel (DATA_WIDTH)
//   data_valid    pixel_in qualifier, one pixel accepted per cycle when high
//   sof           start of frame, meaningful only with data_valid
//   window_out    flattened window; element (r,c) at [(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH],
//                 r=0 oldest row, c=0 oldest column
//   window_valid  one-cycle pulse when window_out/col_out/row_out hold a full window
//   col_out       column of window centre pixel
//   row_out       row of window centre pixel
//   sof_err       (optional) pulses when sof arrives with counters not at (0,0)
module window_line_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int WIN          = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            pixel_in,
  input  logic                             data_valid,
  input  logic                             sof,
  output logic [WIN*WIN*DATA_WIDTH-1:0]    window_out,
  output logic                             window_valid,
  output logic [$clog2(LINE_WIDTH)-1:0]    col_out,
  output logic [$clog2(FRAME_HEIGHT)-1:0]  row_out
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
  ,
  output logic                             sof_err
`endif
);

  localparam int CW   = $clog2(LINE_WIDTH);
  localparam int RW   = $clog2(FRAME_HEIGHT);
  localparam int HALF = (WIN - 1) / 2;

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [CW-1:0] COL_GATE = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_GATE = RW'(WIN - 1);
  localparam logic [CW-1:0] HALF_C   = CW'(HALF);
  localparam logic [RW-1:0] HALF_R   = RW'(HALF);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic          realign;

  logic [DATA_WIDTH-1:0] line_mem  [WIN-1][LINE_WIDTH];
  logic [DATA_WIDTH-1:0] col_vec   [WIN];
  logic [DATA_WIDTH-1:0] shift_reg [WIN][WIN];

  // An accepted sof pixel is treated as position (0,0) whatever the counters say.
  assign realign = data_valid && sof;
  assign eff_col = realign ? '0 : col;
  assign eff_row = realign ? '0 : row;

  // Column vector, oldest line first; the last entry is the pixel being accepted.
  always_comb begin
    for (int r = 0; r < WIN; r++) col_vec[r] = '0;
    for (int r = 0; r < WIN - 1; r++) col_vec[r] = line_mem[WIN-2-r][eff_col];
    col_vec[WIN-1] = pixel_in;
  end

  // Line memories are never cleared; the row gate keeps stale lines out of valid windows.
  always_ff @(posedge clk) begin
    if (!rst && data_valid) begin
      line_mem[0][eff_col] <= pixel_in;
      for (int k = 1; k < WIN - 1; k++) line_mem[k][eff_col] <= line_mem[k-1][eff_col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      col_out      <= '0;
      row_out      <= '0;
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) shift_reg[r][c] <= '0;
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
      sof_err      <= 1'b0;
`endif
    end else begin
      window_valid <= 1'b0;
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
      sof_err      <= 1'b0;
`endif
      if (data_valid) begin
        if (eff_col == COL_LAST) begin
          col <= '0;
          row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end

        // Shift registers are not flushed at line start; the column gate hides
        // windows that straddle a line boundary.
        for (int r = 0; r < WIN; r++) begin
          for (int c = 0; c < WIN - 1; c++) shift_reg[r][c] <= shift_reg[r][c+1];
          shift_reg[r][WIN-1] <= col_vec[r];
        end

        window_valid <= (eff_row >= ROW_GATE) && (eff_col >= COL_GATE);
        col_out      <= eff_col - HALF_C;
        row_out      <= eff_row - HALF_R;
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
        sof_err      <= sof && ((col != '0) || (row != '0));
`endif
      end
    end
  end

  always_comb begin
    window_out = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        window_out[(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH] = shift_reg[r][c];
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// tb/tb_window_line_buffer.sv - self-checking bench for window_line_buffer
module tb_window_line_buffer;

  localparam int DW = 6;
  localparam int LW = 10;
  localparam int FH = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [DW-1:0] pixel_in = '0;
  logic         data_valid = 1'b0;
  logic         sof = 1'b0;

  logic [53:0]  win3;
  logic         valid3;
  logic [3:0]   col3;
  logic [2:0]   row3;
  logic [149:0] win5;
  logic         valid5;
  logic [3:0]   col5;
  logic [2:0]   row5;
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
  logic         sof_err3;
  logic         sof_err5;
`endif

  window_line_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .WIN(3)) dut3 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .data_valid(data_valid), .sof(sof),
    .window_out(win3), .window_valid(valid3), .col_out(col3), .row_out(row3)
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
    , .sof_err(sof_err3)
`endif
  );

  window_line_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .WIN(5)) dut5 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .data_valid(data_valid), .sof(sof),
    .window_out(win5), .window_valid(valid5), .col_out(col5), .row_out(row5)
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
    , .sof_err(sof_err5)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int u5_pulses = 0;
  int err_pulses = 0;

  typedef struct {
    logic        dv;
    logic        sof;
    int          pix;
    logic        exp_valid;
    logic        chk_data;
    logic [3:0]  exp_col;
    logic [2:0]  exp_row;
    logic [53:0] exp_win;
  } vec_t;

  vec_t tbl[29];

  // Expected 3x3 window centred at (rc,cc) of an image whose pixel is row*10+col.
  function automatic logic [53:0] exp_win(input int rc, input int cc);
    logic [53:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*6 +: 6] = 6'((rc - 1 + r) * 10 + (cc - 1 + c));
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input int p);
    @(negedge clk);
    data_valid = v;
    sof = s;
    pixel_in = 6'(p);
    @(posedge clk);
    #1;
    if (valid5) u5_pulses++;
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
    if (sof_err3) err_pulses++;
`endif
  endtask

  initial begin
    logic [53:0] lit22;
    int n, r, c, cnt_frame, cnt_line2, bad_col, early;
    lit22 = {6'd22, 6'd21, 6'd20, 6'd12, 6'd11, 6'd10, 6'd2, 6'd1, 6'd0};

    // Frame 0 start: pixels 0..25 with a three-cycle stall after pixel 24.
    n = 0;
    for (int p = 0; p <= 25; p++) begin
      if (p == 25) begin
        for (int s = 0; s < 3; s++) begin
          tbl[n].dv = 1'b0; tbl[n].sof = 1'b0; tbl[n].pix = 0;
          tbl[n].exp_valid = 1'b0; tbl[n].chk_data = 1'b1;
          tbl[n].exp_col = 4'd3; tbl[n].exp_row = 3'd1; tbl[n].exp_win = exp_win(1, 3);
          n++;
        end
      end
      r = p / 10;
      c = p % 10;
      tbl[n].dv = 1'b1; tbl[n].sof = (p == 0); tbl[n].pix = p;
      tbl[n].exp_valid = (r >= 2) && (c >= 2);
      tbl[n].chk_data = tbl[n].exp_valid;
      tbl[n].exp_col = 4'(c - 1); tbl[n].exp_row = 3'(r - 1);
      tbl[n].exp_win = tbl[n].exp_valid ? exp_win(r - 1, c - 1) : '0;
      n++;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(valid3), 64'd0);
    chk("reset_col", 64'(col3), 64'd0);
    chk("reset_row", 64'(row3), 64'd0);
    chk("reset_window", 64'(win3), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Warm-up and stall via table
    for (int i = 0; i < 29; i++) begin
      step(tbl[i].dv, tbl[i].sof, tbl[i].pix);
      chk($sformatf("tbl%0d_valid", i), 64'(valid3), 64'(tbl[i].exp_valid));
      if (tbl[i].chk_data) begin
        chk($sformatf("tbl%0d_col", i), 64'(col3), 64'(tbl[i].exp_col));
        chk($sformatf("tbl%0d_row", i), 64'(row3), 64'(tbl[i].exp_row));
        chk($sformatf("tbl%0d_window", i), 64'(win3), 64'(tbl[i].exp_win));
      end
    end

    // Rest of frame 0; WIN=5 first window at pixel 44
    for (int p = 26; p < 50; p++) begin
      step(1'b1, 1'b0, p);
      if (p == 44) begin
        chk("w5_valid", 64'(valid5), 64'd1);
        chk("w5_pulses", 64'(u5_pulses), 64'd1);
        chk("w5_col", 64'(col5), 64'd2);
        chk("w5_row", 64'(row5), 64'd2);
        chk("w5_elem00", 64'(win5[0 +: 6]), 64'd0);
        chk("w5_elem44", 64'(win5[24*6 +: 6]), 64'd44);
      end
    end

    // Frame 1 without sof: count pulses, check no border windows
    cnt_frame = 0; cnt_line2 = 0; bad_col = 0;
    for (int p = 0; p < 50; p++) begin
      step(1'b1, 1'b0, p);
      if (valid3) begin
        cnt_frame++;
        if (p / 10 == 2) cnt_line2++;
        if (p % 10 < 2) bad_col++;
      end
      if (p == 22) begin
        chk("f1_p22_valid", 64'(valid3), 64'd1);
        chk("f1_p22_window", 64'(win3), 64'(lit22));
        chk("f1_p22_col", 64'(col3), 64'd1);
        chk("f1_p22_row", 64'(row3), 64'd1);
      end
    end
    chk("f1_pulses_frame", 64'(cnt_frame), 64'd24);
    chk("f1_pulses_line2", 64'(cnt_line2), 64'd8);
    chk("f1_border_windows", 64'(bad_col), 64'd0);

    // Frame 2 truncated at (3,4) by an early sof
    for (int p = 0; p < 34; p++) step(1'b1, 1'b0, p);
    step(1'b1, 1'b1, 0);
    chk("sof_valid", 64'(valid3), 64'd0);
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
    chk("sof_err_pulse", 64'(sof_err3), 64'd1);
`endif
    early = 0;
    for (int p = 1; p < 37; p++) begin
      step(1'b1, 1'b0, p);
      if (p < 22 && valid3) early++;
      if (p == 22) begin
        chk("realign_valid", 64'(valid3), 64'd1);
        chk("realign_window", 64'(win3), 64'(lit22));
        chk("realign_col", 64'(col3), 64'd1);
        chk("realign_row", 64'(row3), 64'd1);
      end
    end
    chk("realign_early", 64'(early), 64'd0);
`ifdef WINDOW_LINE_BUFFER_SOF_ERR_EN
    chk("sof_err_total", 64'(err_pulses), 64'd1);
`endif

    // Mid-frame reset at pixel 37
    @(negedge clk);
    rst = 1'b1; data_valid = 1'b1; sof = 1'b0; pixel_in = 6'd37;
    @(posedge clk);
    #1;
    chk("midrst_valid", 64'(valid3), 64'd0);
    chk("midrst_col", 64'(col3), 64'd0);
    chk("midrst_row", 64'(row3), 64'd0);
    chk("midrst_window", 64'(win3), 64'd0);
    @(negedge clk);
    rst = 1'b0; data_valid = 1'b0;
    early = 0;
    for (int p = 0; p <= 22; p++) begin
      step(1'b1, 1'b0, p);
      if (p < 22 && valid3) early++;
    end
    chk("midrst_early", 64'(early), 64'd0);
    chk("midrst_first_valid", 64'(valid3), 64'd1);
    chk("midrst_window22", 64'(win3), 64'(lit22));
    chk("midrst_col22", 64'(col3), 64'd1);
    chk("midrst_row22", 64'(row3), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Parametrised successor to the single line delay.
- Buffers WIN-1 image lines in circular line memories plus per-row horizontal shift registers, and emits a full WIN x WIN pixel neighbourhood per accepted pixel.
- Sits between the pixel source and the Sobel/convolution kernel stages.
- Tracks column/row position and frame start, and reports the window centre coordinate.

Parameters:
- DATA_WIDTH, 8, bits per pixel
- LINE_WIDTH, 640, pixels per line (>= WIN)
- FRAME_HEIGHT, 480, lines per frame (>= WIN)
- WIN, 3, window size; odd, legal values 3 or 5

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pixel_in  in  DATA_WIDTH  input pixel
- data_valid  in  1  pixel_in qualifier; one pixel accepted per cycle when high
- sof  in  1  start of frame; meaningful only with data_valid
- window_out  out  WIN*WIN*DATA_WIDTH  flattened window
- window_valid  out  1  window_out/col_out/row_out valid
- col_out  out  $clog2(LINE_WIDTH)  column of window centre pixel
- row_out  out  $clog2(FRAME_HEIGHT)  row of window centre pixel

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- Reset values: counters 0; window_out 0; window_valid 0; col_out 0; row_out 0; shift registers 0. Line memory contents are not cleared; row gating masks stale data.
- Position counters: col 0..LINE_WIDTH-1 and row 0..FRAME_HEIGHT-1. They advance only on data_valid.
  - col wraps to 0 at LINE_WIDTH-1 and row increments.
  - row wraps to 0 after (FRAME_HEIGHT-1, LINE_WIDTH-1), so back-to-back frames need no sof.
- sof: data_valid && sof forces the accepted pixel to position (0,0) regardless of counter state. The counters then continue from (0,1).
- Line memories: WIN-1 memories, each LINE_WIDTH deep, sharing address = col. On an accepted pixel:
  - line[0] <= pixel_in
  - line[k] <= old line[k-1]
  - Column vector = {line[WIN-2]..line[0] old values, pixel_in}, oldest row first.
- Horizontal shift: each of the WIN rows shifts its column value in on acceptance, giving a WIN-deep register per row.
- Window layout: element (r,c) occupies bits [(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH]. r=0 is the oldest (top) row; c=0 is the oldest (leftmost) column. Element (WIN-1,WIN-1) is the pixel just accepted.
- Latency: all outputs register 1 cycle after the accepting edge.
- window_valid is high for exactly 1 cycle per accepted pixel when row >= WIN-1 and col >= WIN-1 (valid region only; no border windows).
- col_out = col-(WIN-1)/2 and row_out = row-(WIN-1)/2 of the accepted pixel.
- Horizontal shift registers are not flushed at line start. Windows spanning a line boundary are suppressed by the col >= WIN-1 gate.
- data_valid low: no state change except window_valid <= 0. window_out, col_out and row_out hold.
- rst mid-frame: counters return to (0,0). No window_valid until WIN-1 fresh lines are accumulated.

Optional Feature:
- Macro WINDOW_LINE_BUFFER_SOF_ERR_EN.
- Defined:
  - Adds output port sof_err (1 bit, reset 0).
  - sof_err pulses high 1 cycle after an accepted sof pixel whose counters were not at (0,0), i.e. a truncated previous frame.
  - Realignment still occurs.
- Undefined: no sof_err port; sof realigns silently.

Test Plan:
- Common setup: LINE_WIDTH=10, FRAME_HEIGHT=5, WIN=3, DATA_WIDTH=6, data_valid=1, pixel = col+row*10, sof with first pixel.
- Warm-up: the first window_valid occurs 1 cycle after accepting pixel 22. Expect rows {0,1,2},{10,11,12},{20,21,22}, col_out=1, row_out=1. There must be no window_valid before that.
- Line/frame wrap:
  - Expect exactly 8 window_valid pulses per qualifying line and 24 per frame.
  - Expect no window at col 0/1.
  - The second frame, which has no sof, restarts at pixel 22 with an identical window.
- Stall: deassert data_valid for 3 cycles after pixel 24. Expect window_valid low for those cycles with window_out held. The next pixel 25 yields window {3,4,5},{13,14,15},{23,24,25}.
- sof realign: assert sof at frame position (3,4). Expect counters to restart at (0,0), no window_valid until (2,2), and, with WINDOW_LINE_BUFFER_SOF_ERR_EN, a single sof_err pulse.
- Mid-frame reset: assert rst for 1 cycle at pixel 37. Expect all outputs 0 the next cycle, then first window_valid after the 23rd accepted post-reset pixel.
- WIN=5 regression: with WIN=5, the first window centre is (2,2) at pixel 44. Check element (0,0)=0 and (4,4)=44.
